ipsxe_floating_point_diffprim: RTL and testbench



---
 rtl/ipsxe_floating_point_diffprim_pkg.sv | 35 +++
 rtl/ipsxe_floating_point_diffprim_fx2fl.sv | 62 ++++++
 rtl/ipsxe_floating_point_diffprim.sv | 115 +++++++++++
 tb/tb_ipsxe_floating_point_diffprim.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ipsxe_floating_point_diffprim_pkg.sv
// Shared constants and helpers for the floating-point difference primitive.
// Fixed point is Q24.8 two's complement. Floats use an 8-bit exponent and a 24-bit significand.
package ipsxe_floating_point_diffprim_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int FIXED_INT_BIT  = 24;
  localparam int FIXED_FRAC_BIT = 8;
  localparam int FLOAT_EXP_BIT  = 8;
  localparam int FLOAT_FRAC_BIT = 24;
  localparam int FLOAT_BIAS     = 2**(FLOAT_EXP_BIT-1) - 1;
  localparam int LOD_W          = $clog2(DATA_WIDTH);

  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam word_t FIXED_MAX      = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam word_t FIXED_MIN      = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam word_t FLOAT_POS_ZERO = '0;

  // Float images of the saturated fixed values: +/-2^(FIXED_INT_BIT-1).
  localparam logic [FLOAT_EXP_BIT-1:0] SAT_FLOAT_EXP =
    FLOAT_EXP_BIT'(FLOAT_BIAS + DATA_WIDTH - 1 - FIXED_FRAC_BIT);
  localparam word_t FLOAT_SAT_POS = {1'b0, SAT_FLOAT_EXP, {(FLOAT_FRAC_BIT-1){1'b0}}};
  localparam word_t FLOAT_SAT_NEG = {1'b1, SAT_FLOAT_EXP, {(FLOAT_FRAC_BIT-1){1'b0}}};

  // Bit index of the most significant one. Returns 0 for a zero input.
  function automatic logic [LOD_W-1:0] lead_one_pos(input word_t v);
    logic [LOD_W-1:0] pos;
    pos = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (v[i]) pos = LOD_W'(i);
    end
    return pos;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_diffprim_fx2fl.sv
// Converts signed fixed point to float with round-to-nearest-even. This block is one register stage.
// A zero input gives +0.0. The two saturation codes map straight to their exact float images.
module ipsxe_floating_point_diffprim_fx2fl
  import ipsxe_floating_point_diffprim_pkg::*;
(
  input  logic  i_aclk,
  input  logic  i_areset,
  input  logic  i_aclken,
  input  word_t i_fixed,
  input  logic  i_valid,
  input  logic  i_ovf,
  output word_t o_float,
  output logic  o_valid,
  output logic  o_overflow
);

  logic                      sign;
  word_t                     mag;
  word_t                     norm;
  logic [LOD_W-1:0]          pos;
  logic [FLOAT_FRAC_BIT-1:0] keep;
  logic                      guard;
  logic                      sticky;
  logic                      round_up;
  logic [FLOAT_FRAC_BIT:0]   sig;
  logic [FLOAT_EXP_BIT-1:0]  exp_c;
  logic [FLOAT_FRAC_BIT-2:0] frac_c;
  word_t                     float_c;

  always_comb begin
    sign     = i_fixed[DATA_WIDTH-1];
    mag      = sign ? (~i_fixed + 1'b1) : i_fixed;
    pos      = lead_one_pos(mag);
    norm     = mag << (LOD_W'(DATA_WIDTH-1) - pos);
    keep     = norm[DATA_WIDTH-1 -: FLOAT_FRAC_BIT];
    guard    = norm[DATA_WIDTH-1-FLOAT_FRAC_BIT];
    sticky   = |norm[DATA_WIDTH-2-FLOAT_FRAC_BIT:0];
    round_up = guard & (sticky | keep[0]);
    sig      = {1'b0, keep} + (FLOAT_FRAC_BIT+1)'(round_up);
    // When rounding carries out, the significand becomes 1.000. The exponent then goes up by one.
    exp_c    = FLOAT_EXP_BIT'(FLOAT_BIAS - FIXED_FRAC_BIT) + FLOAT_EXP_BIT'(pos)
             + FLOAT_EXP_BIT'(sig[FLOAT_FRAC_BIT]);
    frac_c   = sig[FLOAT_FRAC_BIT] ? sig[FLOAT_FRAC_BIT-1:1] : sig[FLOAT_FRAC_BIT-2:0];
    if (i_fixed == '0)            float_c = FLOAT_POS_ZERO;
    else if (i_fixed == FIXED_MIN) float_c = FLOAT_SAT_NEG;
    else if (i_fixed == FIXED_MAX) float_c = FLOAT_SAT_POS;
    else                           float_c = {sign, exp_c, frac_c};
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      o_float    <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else if (i_aclken) begin
      o_valid    <= i_valid;
      o_overflow <= i_valid & i_ovf;
      if (i_valid) o_float <= float_c;
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_diffprim.sv
// First-difference engine: y[n] = a[n] - a[n-1], computed in fixed point.
// The stages are float->fixed, then subtract against the history, then fixed->float in the fx2fl sub-module.
module ipsxe_floating_point_diffprim
  import ipsxe_floating_point_diffprim_pkg::*;
#(
  parameter int DATA_WIDTH     = ipsxe_floating_point_diffprim_pkg::DATA_WIDTH,
  parameter int FIXED_INT_BIT  = ipsxe_floating_point_diffprim_pkg::FIXED_INT_BIT,
  parameter int FIXED_FRAC_BIT = ipsxe_floating_point_diffprim_pkg::FIXED_FRAC_BIT,
  parameter int FLOAT_EXP_BIT  = ipsxe_floating_point_diffprim_pkg::FLOAT_EXP_BIT,
  parameter int FLOAT_FRAC_BIT = ipsxe_floating_point_diffprim_pkg::FLOAT_FRAC_BIT
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  input  logic                  i_aclken,
  input  logic [DATA_WIDTH-1:0] i_axi4s_a_tdata,
  input  logic                  i_axi4s_tvalid,
  input  logic                  i_clear,
  output logic [DATA_WIDTH-1:0] o_axi4s_result_tdata,
  output logic                  o_axi4s_result_tvalid,
  output logic                  o_overflow
);

  localparam int BIAS = 2**(FLOAT_EXP_BIT-1) - 1;
  // An exponent at or above EXP_SAT gives |x| >= 2^(FIXED_INT_BIT-1).
  // At EXP_ALIGN the significand already sits on the fixed-point grid, so no shift is needed.
  localparam logic [FLOAT_EXP_BIT-1:0] EXP_SAT   = FLOAT_EXP_BIT'(BIAS + FIXED_INT_BIT - 1);
  localparam logic [FLOAT_EXP_BIT-1:0] EXP_ALIGN =
    FLOAT_EXP_BIT'(BIAS + FLOAT_FRAC_BIT - 1 - FIXED_FRAC_BIT);

  logic                      a_sign;
  logic [FLOAT_EXP_BIT-1:0]  a_exp;
  logic [FLOAT_FRAC_BIT-2:0] a_man;
  logic [DATA_WIDTH-1:0]     a_sig;
  logic [DATA_WIDTH-1:0]     a_mag;
  logic [DATA_WIDTH-1:0]     fx_c;
  logic                      ovf1_c;

  always_comb begin
    a_sign = i_axi4s_a_tdata[DATA_WIDTH-1];
    a_exp  = i_axi4s_a_tdata[DATA_WIDTH-2 -: FLOAT_EXP_BIT];
    a_man  = i_axi4s_a_tdata[FLOAT_FRAC_BIT-2:0];
    a_sig  = DATA_WIDTH'({1'b1, a_man});
    a_mag  = '0;
    fx_c   = '0;
    ovf1_c = 1'b0;
    if (a_exp == {FLOAT_EXP_BIT{1'b1}}) begin
      // NaN always saturates positive. Only -inf saturates negative.
      ovf1_c = 1'b1;
      fx_c   = (a_sign && a_man == '0) ? FIXED_MIN : FIXED_MAX;
    end else if (a_exp >= EXP_SAT) begin
      ovf1_c = 1'b1;
      fx_c   = a_sign ? FIXED_MIN : FIXED_MAX;
    end else if (a_exp != '0) begin
      if (a_exp >= EXP_ALIGN) a_mag = a_sig << (a_exp - EXP_ALIGN);
      else                    a_mag = a_sig >> (EXP_ALIGN - a_exp);
      fx_c = a_sign ? (~a_mag + 1'b1) : a_mag;
    end
  end

  logic                  s1_valid;
  logic                  s1_clear;
  logic                  s1_ovf;
  logic [DATA_WIDTH-1:0] s1_fx;
  logic [DATA_WIDTH-1:0] hist;
  logic [DATA_WIDTH-1:0] hist_eff;
  logic [DATA_WIDTH:0]   diff;
  logic                  ovf2_c;
  logic [DATA_WIDTH-1:0] d_c;
  logic                  s2_valid;
  logic                  s2_ovf;
  logic [DATA_WIDTH-1:0] s2_d;

  always_comb begin
    hist_eff = s1_clear ? '0 : hist;
    diff     = {s1_fx[DATA_WIDTH-1], s1_fx} - {hist_eff[DATA_WIDTH-1], hist_eff};
    ovf2_c   = diff[DATA_WIDTH] ^ diff[DATA_WIDTH-1];
    d_c      = ovf2_c ? (diff[DATA_WIDTH] ? FIXED_MIN : FIXED_MAX) : diff[DATA_WIDTH-1:0];
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      s1_valid <= 1'b0;
      s1_clear <= 1'b0;
      s1_ovf   <= 1'b0;
      s1_fx    <= '0;
      s2_valid <= 1'b0;
      s2_ovf   <= 1'b0;
      s2_d     <= '0;
      hist     <= '0;
    end else if (i_aclken) begin
      s1_valid <= i_axi4s_tvalid;
      s1_clear <= i_axi4s_tvalid & i_clear;
      s1_ovf   <= ovf1_c;
      s1_fx    <= fx_c;
      s2_valid <= s1_valid;
      s2_ovf   <= s1_ovf | ovf2_c;
      s2_d     <= d_c;
      // The history holds the converted input, not the saturated difference.
      if (s1_valid) hist <= s1_fx;
    end
  end

  ipsxe_floating_point_diffprim_fx2fl u_fx2fl (
    .i_aclk     (i_aclk),
    .i_areset   (i_areset),
    .i_aclken   (i_aclken),
    .i_fixed    (s2_d),
    .i_valid    (s2_valid),
    .i_ovf      (s2_ovf),
    .o_float    (o_axi4s_result_tdata),
    .o_valid    (o_axi4s_result_tvalid),
    .o_overflow (o_overflow)
  );

endmodule

// File: tb/tb_ipsxe_floating_point_diffprim.sv
// Directed bench for the difference primitive. Expected floats were worked out by hand.
`timescale 1ns/1ps
module tb_ipsxe_floating_point_diffprim;

  logic        clk;
  logic        i_areset;
  logic        i_aclken;
  logic [31:0] i_axi4s_a_tdata;
  logic        i_axi4s_tvalid;
  logic        i_clear;
  logic [31:0] o_axi4s_result_tdata;
  logic        o_axi4s_result_tvalid;
  logic        o_overflow;

  ipsxe_floating_point_diffprim dut (
    .i_aclk                (clk),
    .i_areset              (i_areset),
    .i_aclken              (i_aclken),
    .i_axi4s_a_tdata       (i_axi4s_a_tdata),
    .i_axi4s_tvalid        (i_axi4s_tvalid),
    .i_clear               (i_clear),
    .o_axi4s_result_tdata  (o_axi4s_result_tdata),
    .o_axi4s_result_tvalid (o_axi4s_result_tvalid),
    .o_overflow            (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] st_data [16];
  logic        st_vld  [16];
  logic        st_clr  [16];
  logic        st_en   [16];
  logic [31:0] ob_data [16];
  logic        ob_vld  [16];
  logic        ob_ovf  [16];
  logic [31:0] ex_data [16];
  logic        ex_vld  [16];
  logic        ex_ovf  [16];

  task automatic idle_inputs();
    i_aclken = 1'b1; i_axi4s_tvalid = 1'b0; i_clear = 1'b0; i_axi4s_a_tdata = '0;
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 16; i++) begin
      st_data[i] = '0; st_vld[i] = 1'b0; st_clr[i] = 1'b0; st_en[i] = 1'b1;
      ex_data[i] = '0; ex_vld[i] = 1'b0; ex_ovf[i] = 1'b0;
      ob_data[i] = '0; ob_vld[i] = 1'b0; ob_ovf[i] = 1'b0;
    end
  endtask

  // Drive row i before the edge, then capture the outputs 1 ns after it.
  // An input in row i shows up in row i+2.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      i_axi4s_a_tdata = st_data[i];
      i_axi4s_tvalid  = st_vld[i];
      i_clear         = st_clr[i];
      i_aclken        = st_en[i];
      @(posedge clk); #1;
      ob_data[i] = o_axi4s_result_tdata;
      ob_vld[i]  = o_axi4s_result_tvalid;
      ob_ovf[i]  = o_overflow;
    end
    idle_inputs();
  endtask

  task automatic do_reset();
    i_areset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    i_areset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_areset = 1'b0;
    #2 i_areset = 1'b1;
    #1;
    total++; if (o_axi4s_result_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got %0b want 0", o_axi4s_result_tvalid); end
    total++; if (o_axi4s_result_tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata got %08h want 00000000", o_axi4s_result_tdata); end
    total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got %0b want 0", o_overflow); end
    @(posedge clk); #1;
    i_areset = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_tables();
    st_data[0] = 32'h3F800000; st_vld[0] = 1'b1;
    st_data[1] = 32'h40400000; st_vld[1] = 1'b1;
    st_data[2] = 32'h40200000; st_vld[2] = 1'b1;
    st_data[3] = 32'h40800000; st_vld[3] = 1'b1; st_clr[3] = 1'b1;
    st_data[4] = 32'h40800000; st_vld[4] = 1'b1;
    ex_vld[2] = 1'b1; ex_data[2] = 32'h3F800000;
    ex_vld[3] = 1'b1; ex_data[3] = 32'h40000000;
    ex_vld[4] = 1'b1; ex_data[4] = 32'hBF000000;
    ex_vld[5] = 1'b1; ex_data[5] = 32'h40800000;
    ex_vld[6] = 1'b1; ex_data[6] = 32'h00000000;
    run(9);
    for (int i = 0; i < 9; i++) begin
      total++; if (ob_vld[i] !== ex_vld[i]) begin bad++; $display("FAIL b2b_vld[%0d] got %0b want %0b", i, ob_vld[i], ex_vld[i]); end
      total++; if (ob_ovf[i] !== ex_ovf[i]) begin bad++; $display("FAIL b2b_ovf[%0d] got %0b want %0b", i, ob_ovf[i], ex_ovf[i]); end
      if (ex_vld[i]) begin
        total++; if (ob_data[i] !== ex_data[i]) begin bad++; $display("FAIL b2b_data[%0d] got %08h want %08h", i, ob_data[i], ex_data[i]); end
      end
    end
  endtask

  task automatic test_truncate();
    do_reset();
    clear_tables();
    st_data[0] = 32'h3B000000; st_vld[0] = 1'b1;
    st_data[1] = 32'h3F800000; st_vld[1] = 1'b1;
    ex_vld[2] = 1'b1; ex_data[2] = 32'h00000000;
    ex_vld[3] = 1'b1; ex_data[3] = 32'h3F800000;
    run(6);
    for (int i = 0; i < 6; i++) begin
      total++; if (ob_vld[i] !== ex_vld[i]) begin bad++; $display("FAIL trunc_vld[%0d] got %0b want %0b", i, ob_vld[i], ex_vld[i]); end
      total++; if (ob_ovf[i] !== ex_ovf[i]) begin bad++; $display("FAIL trunc_ovf[%0d] got %0b want %0b", i, ob_ovf[i], ex_ovf[i]); end
      if (ex_vld[i]) begin
        total++; if (ob_data[i] !== ex_data[i]) begin bad++; $display("FAIL trunc_data[%0d] got %08h want %08h", i, ob_data[i], ex_data[i]); end
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    clear_tables();
    st_data[0] = 32'h7F800000; st_vld[0] = 1'b1;                      // +inf
    st_data[1] = 32'hFF800000; st_vld[1] = 1'b1;                      // -inf
    st_data[2] = 32'h4B000000; st_vld[2] = 1'b1; st_clr[2] = 1'b1;    // 2^23, out of range
    st_data[3] = 32'h7FC00000; st_vld[3] = 1'b1;                      // NaN
    st_data[4] = 32'h3F800000; st_vld[4] = 1'b1;                      // 1.0 - 0x7FFFFFFF
    ex_vld[2] = 1'b1; ex_data[2] = 32'h4B000000; ex_ovf[2] = 1'b1;
    ex_vld[3] = 1'b1; ex_data[3] = 32'hCB000000; ex_ovf[3] = 1'b1;
    ex_vld[4] = 1'b1; ex_data[4] = 32'h4B000000; ex_ovf[4] = 1'b1;
    ex_vld[5] = 1'b1; ex_data[5] = 32'h00000000; ex_ovf[5] = 1'b1;
    ex_vld[6] = 1'b1; ex_data[6] = 32'hCAFFFFFE; ex_ovf[6] = 1'b0;
    run(8);
    for (int i = 0; i < 8; i++) begin
      total++; if (ob_vld[i] !== ex_vld[i]) begin bad++; $display("FAIL sat_vld[%0d] got %0b want %0b", i, ob_vld[i], ex_vld[i]); end
      total++; if (ob_ovf[i] !== ex_ovf[i]) begin bad++; $display("FAIL sat_ovf[%0d] got %0b want %0b", i, ob_ovf[i], ex_ovf[i]); end
      if (ex_vld[i]) begin
        total++; if (ob_data[i] !== ex_data[i]) begin bad++; $display("FAIL sat_data[%0d] got %08h want %08h", i, ob_data[i], ex_data[i]); end
      end
    end
  endtask

  task automatic test_clock_enable();
    do_reset();
    clear_tables();
    st_data[0] = 32'h3F800000; st_vld[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      st_data[i] = 32'h40000000; st_vld[i] = 1'b1; st_en[i] = 1'b0;
    end
    st_data[6] = 32'h40000000; st_vld[6] = 1'b1;
    ex_vld[7] = 1'b1; ex_vld[8] = 1'b1;
    for (int i = 7; i < 11; i++) ex_data[i] = 32'h3F800000;
    run(11);
    for (int i = 0; i < 11; i++) begin
      total++; if (ob_vld[i] !== ex_vld[i]) begin bad++; $display("FAIL cen_vld[%0d] got %0b want %0b", i, ob_vld[i], ex_vld[i]); end
      total++; if (ob_ovf[i] !== ex_ovf[i]) begin bad++; $display("FAIL cen_ovf[%0d] got %0b want %0b", i, ob_ovf[i], ex_ovf[i]); end
      total++; if (ob_data[i] !== ex_data[i]) begin bad++; $display("FAIL cen_data[%0d] got %08h want %08h", i, ob_data[i], ex_data[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    clear_tables();
    st_data[0] = 32'h3F800000; st_vld[0] = 1'b1;
    st_data[1] = 32'h40000000; st_vld[1] = 1'b1;
    st_data[2] = 32'h40E00000; st_vld[2] = 1'b1;
    run(3);
    total++; if (ob_vld[2] !== 1'b1 || ob_data[2] !== 32'h3F800000) begin
      bad++; $display("FAIL mid_pre got vld=%0b data=%08h want vld=1 data=3f800000", ob_vld[2], ob_data[2]);
    end
    #2 i_areset = 1'b1;
    #1;
    total++; if (o_axi4s_result_tvalid !== 1'b0) begin bad++; $display("FAIL mid_tvalid got %0b want 0", o_axi4s_result_tvalid); end
    total++; if (o_axi4s_result_tdata !== 32'h0) begin bad++; $display("FAIL mid_tdata got %08h want 00000000", o_axi4s_result_tdata); end
    total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL mid_ovf got %0b want 0", o_overflow); end
    @(posedge clk); #1;
    i_areset = 1'b0;
    clear_tables();
    st_data[0] = 32'h40A00000; st_vld[0] = 1'b1;
    ex_vld[2] = 1'b1; ex_data[2] = 32'h40A00000;
    run(6);
    for (int i = 0; i < 6; i++) begin
      total++; if (ob_vld[i] !== ex_vld[i]) begin bad++; $display("FAIL mid_vld[%0d] got %0b want %0b", i, ob_vld[i], ex_vld[i]); end
      if (ex_vld[i]) begin
        total++; if (ob_data[i] !== ex_data[i]) begin bad++; $display("FAIL mid_data[%0d] got %08h want %08h", i, ob_data[i], ex_data[i]); end
      end
    end
  endtask

  initial begin
    i_areset = 1'b0;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_truncate();
    test_saturate();
    test_clock_enable();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
